fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage. Owns the program counter and drives the instruction-memory read port.
- Presents {instr, pc, pc+4} plus a valid strobe to the IF/ID latch.
- Absorbs memory wait states, hazard-unit stalls and branch/jump redirects.
- Upstream: icache/memory-control `ihit`. Downstream: IF/ID latch `instr_i`/`curr_pc_i`/`npc_i`/`en`.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment between sequential instructions.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  reset; asynchronous, active-low.
- ihit  input  1  instruction memory returns data for the current request this cycle.
- imemload  input  32  instruction word, valid when ihit=1.
- iREN  output  1  instruction read request.
- imemaddr  output  32  request address; equals the pc register.
- stall  input  1  hazard unit freeze; downstream cannot accept this cycle.
- redirect_en  input  1  taken branch/jump from a later stage.
- redirect_pc  input  32  redirect target.
- halt  input  1  halt committed; fetch stops permanently.
- instr_o  output  32  instruction to IF/ID.
- curr_pc_o  output  32  address of instr_o.
- npc_o  output  32  curr_pc_o + PC_STEP.
- valid_o  output  1  instruction handed over this cycle; drives IF/ID en.

Behaviour:
- State: pc (32), tgt_r (32), buf_instr/buf_pc (32 each), FSM {FETCH, DISCARD, HOLD, HALTED}.
- Reset (async, nRST=0):
  - pc=PC_RESET, state=FETCH, tgt_r=0, buffers=0.
  - Outputs gated while nRST=0: iREN=0, valid_o=0.
  - instr_o/curr_pc_o/npc_o = 0.
- Memory contract: while iREN=1 and ihit=0, imemaddr is held stable. A request is never abandoned mid-flight.
- Output muxing is combinational from state and registers; no extra latency beyond memory.
- Priority in every state: halt > redirect_en > ihit/stall.
- FETCH: iREN=1.
  - ihit & !redirect & !stall: valid_o=1, instr_o=imemload, curr_pc_o=pc, npc_o=pc+PC_STEP; pc<=pc+PC_STEP.
  - ihit & !redirect & stall: valid_o=0; buf<= {imemload, pc}; pc<=pc+PC_STEP; go HOLD.
  - redirect & ihit: returned word dropped, valid_o=0; pc<=redirect_pc; stay FETCH.
  - redirect & !ihit: tgt_r<=redirect_pc; go DISCARD.
  - !ihit otherwise: hold.
- DISCARD: iREN=1 on the old pc; valid_o=0.
  - A new redirect_en overwrites tgt_r (latest wins).
  - On ihit: data dropped; pc<= redirect_en ? redirect_pc : tgt_r; go FETCH.
- HOLD: iREN=0.
  - !stall & !redirect: valid_o=1 with buf_instr, buf_pc, buf_pc+PC_STEP; go FETCH.
  - redirect (regardless of stall): buffer dropped, valid_o=0; pc<=redirect_pc; go FETCH.
  - stall: remain; outputs show buffer, valid_o=0.
- HALTED: iREN=0, valid_o=0, pc frozen. Sticky until nRST.
  - halt asserted in any state goes to HALTED next edge; that cycle valid_o=0.
  - If halt arrives with a request in flight and ihit=0, the request is dropped.
- Arithmetic: pc+PC_STEP wraps modulo 2^32; 32'hFFFF_FFFC+4 = 0. No alignment checking; redirect_pc is used as-is.
- valid_o is never asserted in the same cycle as redirect_en or halt.

Test Plan:
- Reset, ihit tied 1, imemload=pc-derived pattern, stall=0 → valid_o every cycle; curr_pc_o = 0, 4, 8, …; npc_o = curr_pc_o+4; iREN=0 while nRST=0.
- ihit delayed 3 cycles per request → imemaddr stable across wait cycles; one valid_o per hit; no duplicated or skipped pc.
- stall asserted on the hit of pc=0x10 for 2 cycles:
  - iREN=0 during the stall cycles.
  - valid_o on release cycle with curr_pc_o=0x10.
  - Next fetch at 0x14.
- redirect_en to 0x200 with ihit=0 at pc=0x8, ihit after 2 cycles:
  - Instruction at 0x8 never valid.
  - Next request imemaddr=0x200.
  - Repeat with a second redirect to 0x300 during DISCARD → target 0x300.
- redirect_en=1 with ihit=1 in the same cycle, and redirect during HOLD with stall=1 → valid_o=0 that cycle; next imemaddr = redirect_pc.
- halt mid-wait at pc=0x40 → iREN=0 and valid_o=0 thereafter, ignoring redirects; nRST pulse mid-HALTED → restart at PC_RESET. Also check wrap at pc=32'hFFFF_FFFC → next 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the program counter, drives the instruction
// memory read port and hands {instr, pc, pc+step} to the IF/ID latch. It
// absorbs memory wait states, downstream stalls, redirects and halt.
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr_o,
  output logic [31:0] curr_pc_o,
  output logic [31:0] npc_o,
  output logic        valid_o
);

  // FETCH: request outstanding; DISCARD: in-flight word belongs to a
  // squashed path; HOLD: fetched word parked while downstream is stalled;
  // HALTED: fetch permanently stopped until reset.
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic [31:0] tgt_r, tgt_nxt_s;
  logic [31:0] buf_instr_r, buf_instr_nxt_s;
  logic [31:0] buf_pc_r, buf_pc_nxt_s;

  logic        ren_s;
  logic        valid_s;
  logic [31:0] instr_s;
  logic [31:0] cpc_s;
  logic [31:0] npc_s;
  logic [31:0] pc_inc_s;
  logic [31:0] buf_npc_s;

  // Sequential successors wrap naturally modulo 2^32.
  assign pc_inc_s  = pc_r + PC_STEP;
  assign buf_npc_s = buf_pc_r + PC_STEP;

  // The request address is always the pc register, so it stays stable
  // for as long as a request waits on ihit.
  assign imemaddr = pc_r;

  // State and datapath registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r     <= FETCH;
      pc_r        <= PC_RESET;
      tgt_r       <= 32'h0000_0000;
      buf_instr_r <= 32'h0000_0000;
      buf_pc_r    <= 32'h0000_0000;
    end else begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      tgt_r       <= tgt_nxt_s;
      buf_instr_r <= buf_instr_nxt_s;
      buf_pc_r    <= buf_pc_nxt_s;
    end
  end

  // Next-state and unresolved outputs; halt beats redirect beats hit/stall.
  always_comb begin
    state_nxt_s     = state_r;
    pc_nxt_s        = pc_r;
    tgt_nxt_s       = tgt_r;
    buf_instr_nxt_s = buf_instr_r;
    buf_pc_nxt_s    = buf_pc_r;
    ren_s           = 1'b0;
    valid_s         = 1'b0;
    instr_s         = 32'h0000_0000;
    cpc_s           = 32'h0000_0000;
    npc_s           = 32'h0000_0000;

    case (state_r)
      FETCH: begin
        ren_s   = 1'b1;
        instr_s = imemload;
        cpc_s   = pc_r;
        npc_s   = pc_inc_s;
        if (halt) begin
          state_nxt_s = HALTED;
        end else if (redirect_en) begin
          if (ihit) begin
            // Returned word is on the wrong path; refetch at the target.
            pc_nxt_s = redirect_pc;
          end else begin
            // Request cannot be abandoned; remember where to go once it lands.
            tgt_nxt_s   = redirect_pc;
            state_nxt_s = DISCARD;
          end
        end else if (ihit) begin
          pc_nxt_s = pc_inc_s;
          if (stall) begin
            buf_instr_nxt_s = imemload;
            buf_pc_nxt_s    = pc_r;
            state_nxt_s     = HOLD;
          end else begin
            valid_s = 1'b1;
          end
        end else begin
          state_nxt_s = FETCH;
        end
      end

      DISCARD: begin
        ren_s = 1'b1;
        if (halt) begin
          state_nxt_s = HALTED;
        end else if (ihit) begin
          pc_nxt_s    = redirect_en ? redirect_pc : tgt_r;
          state_nxt_s = FETCH;
        end else if (redirect_en) begin
          tgt_nxt_s = redirect_pc;
        end else begin
          state_nxt_s = DISCARD;
        end
      end

      HOLD: begin
        instr_s = buf_instr_r;
        cpc_s   = buf_pc_r;
        npc_s   = buf_npc_s;
        if (halt) begin
          state_nxt_s = HALTED;
        end else if (redirect_en) begin
          pc_nxt_s    = redirect_pc;
          state_nxt_s = FETCH;
        end else if (!stall) begin
          valid_s     = 1'b1;
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = HOLD;
        end
      end

      HALTED: begin
        state_nxt_s = HALTED;
      end

      default: begin
        state_nxt_s = FETCH;
      end
    endcase
  end

  // Outputs are forced quiet while reset is asserted.
  always_comb begin
    if (nRST) begin
      iREN      = ren_s;
      valid_o   = valid_s;
      instr_o   = instr_s;
      curr_pc_o = cpc_s;
      npc_o     = npc_s;
    end else begin
      iREN      = 1'b0;
      valid_o   = 1'b0;
      instr_o   = 32'h0000_0000;
      curr_pc_o = 32'h0000_0000;
      npc_o     = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a bench-side memory responder, a flag-based
// reference model that pushes expected handovers, and a negedge monitor.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] imemload = 32'h0;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        iREN;
  logic [31:0] imemaddr;
  logic [31:0] instr_o;
  logic [31:0] curr_pc_o;
  logic [31:0] npc_o;
  logic        valid_o;

  fetch_unit #(.PC_RESET(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .iREN(iREN),
    .imemaddr(imemaddr), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .halt(halt), .instr_o(instr_o),
    .curr_pc_o(curr_pc_o), .npc_o(npc_o), .valid_o(valid_o)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // Memory content is a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC3A5_1E0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];
  logic        exp_iren = 1'b0;
  logic [31:0] exp_addr = 32'h0;
  bit          m_halted, m_dead, m_hold;
  logic [31:0] m_pc, m_tgt, m_buf_pc;

  // Model: after inputs settle, decide this cycle's handover and the next fetch address.
  always @(posedge CLK) begin
    #3;
    if (!nRST) begin
      m_halted = 0; m_dead = 0; m_hold = 0;
      m_pc = 32'h0; m_tgt = 32'h0; m_buf_pc = 32'h0;
      exp_iren = 1'b0;
      exp_addr = 32'h0;
    end else begin
      exp_iren = !m_halted && !m_hold;
      exp_addr = m_pc;
      if (m_halted) begin
        m_halted = 1;
      end else if (halt) begin
        m_halted = 1;
      end else if (m_hold) begin
        if (redirect_en) begin
          m_hold = 0;
          m_pc = redirect_pc;
        end else if (!stall) begin
          exp_q.push_back(m_buf_pc);
          m_hold = 0;
        end
      end else if (m_dead) begin
        if (ihit) begin
          m_pc = redirect_en ? redirect_pc : m_tgt;
          m_dead = 0;
        end else if (redirect_en) begin
          m_tgt = redirect_pc;
        end
      end else if (redirect_en) begin
        if (ihit) m_pc = redirect_pc;
        else begin
          m_dead = 1;
          m_tgt = redirect_pc;
        end
      end else if (ihit) begin
        if (stall) begin
          m_hold = 1;
          m_buf_pc = m_pc;
        end else begin
          exp_q.push_back(m_pc);
        end
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] mon_pc;

  // Monitor: compare request port every cycle and pop the scoreboard on each handover.
  always @(negedge CLK) begin
    chk("iren", 32'(iREN), 32'(exp_iren));
    chk("imemaddr", imemaddr, exp_addr);
    chk("valid", 32'(valid_o), 32'(exp_q.size() != 0));
    if (valid_o === 1'b1 && exp_q.size() != 0) begin
      mon_pc = exp_q.pop_front();
      chk("curr_pc", curr_pc_o, mon_pc);
      chk("instr", instr_o, mem_word(mon_pc));
      chk("npc", npc_o, mon_pc + 32'd4);
    end else begin
      exp_q.delete();
    end
    if (!nRST) begin
      chk("rst_instr", instr_o, 32'h0);
      chk("rst_pc", curr_pc_o, 32'h0);
      chk("rst_npc", npc_o, 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  int lat = 0;
  bit lat_rand = 0;
  int cnt = 0;

  // One cycle: memory responder answers after 'lat' wait cycles; controls default low.
  task automatic mem_step();
    @(posedge CLK);
    #1;
    if (iREN !== 1'b1) begin
      ihit = 1'b0;
      cnt = 0;
    end else begin
      ihit = (cnt >= lat);
      if (ihit) begin
        cnt = 0;
        if (lat_rand) lat = $urandom_range(0, 3);
      end else begin
        cnt++;
      end
    end
    imemload = ihit ? mem_word(imemaddr) : $urandom();
    stall = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = $urandom();
    halt = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    repeat (3) mem_step();
    nRST = 1'b1;
  endtask

  // Step until the request at address a is on the bus with the given ihit value.
  task automatic wait_at(input logic [31:0] a, input logic want_hit, input string name);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      mem_step();
      if (iREN === 1'b1 && ihit == want_hit && imemaddr === a) ok = 1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: timeout waiting for addr %h", name, a);
    end
  endtask

  initial begin
    nRST = 1'b0;
    repeat (3) mem_step();
    nRST = 1'b1;

    // zero-wait streaming, then stall on the hit at 0x10
    lat = 0;
    wait_at(32'h10, 1'b1, "wait_0x10");
    stall = 1'b1;
    mem_step();
    stall = 1'b1;
    mem_step();
    repeat (6) mem_step();

    // three wait states per request
    lat = 3;
    repeat (30) mem_step();

    // redirect during a wait at 0x8, then a second redirect during the discard
    do_reset();
    lat = 3;
    wait_at(32'h8, 1'b0, "wait_0x8");
    redirect_en = 1'b1;
    redirect_pc = 32'h200;
    mem_step();
    if (!ihit) begin
      redirect_en = 1'b1;
      redirect_pc = 32'h300;
    end
    repeat (12) mem_step();

    // redirect in the same cycle as a hit
    lat = 0;
    mem_step();
    redirect_en = 1'b1;
    redirect_pc = 32'h400;
    repeat (3) mem_step();

    // redirect while holding a stalled word
    mem_step();
    stall = 1'b1;
    mem_step();
    stall = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'h500;
    repeat (4) mem_step();

    // halt mid-wait at 0x40; redirects must be ignored afterwards
    do_reset();
    lat = 3;
    wait_at(32'h40, 1'b0, "wait_0x40");
    halt = 1'b1;
    repeat (10) begin
      mem_step();
      redirect_en = 1'($urandom_range(0, 1));
      redirect_pc = $urandom() & 32'hFFFF_FFFC;
    end

    // reset out of HALTED, then wrap through 0xFFFF_FFFC
    do_reset();
    lat = 0;
    repeat (5) mem_step();
    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFF4;
    repeat (7) mem_step();

    // randomized traffic
    lat_rand = 1;
    for (int i = 0; i < 2000; i++) begin
      if (i % 250 == 249) do_reset();
      mem_step();
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 11) == 0) begin
        redirect_en = 1'b1;
        redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFC);
      end
      if ($urandom_range(0, 299) == 0) halt = 1'b1;
    end

    repeat (2) mem_step();
    @(negedge CLK);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
